// File: rtl/boot_memory.sv
// Boot memory: 256x8 RAM filled by a byte-stream loader while the processor
// is held in reset, then served to the processor over a shared data bus.
module boot_memory #(
    parameter logic [7:0] LOAD_BASE = 8'h00,
    parameter logic [7:0] OUT_ADDR  = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] mar,
    input  logic       we,
    inout  wire  [7:0] mbr,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       cpu_reset,
    output logic [7:0] out_port,
    output logic [8:0] ld_count
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] mem [256];
    logic [7:0] load_addr;
    logic       drive;
    logic       ld_fire;
    logic       cpu_wr;

    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        cpu_reset = 1'b0;
        drive     = 1'b0;
        unique case (state_q)
            LOAD: begin
                ld_ready  = 1'b1;
                cpu_reset = 1'b1;
                if (ld_valid && ld_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                drive = !we;
            end
            default: state_d = LOAD;
        endcase
    end

    assign ld_fire = ld_valid && ld_ready;
    assign cpu_wr  = (state_q == RUN) && we;

    // The bus is only ever driven for a RUN read, so the processor owns it otherwise.
    assign mbr = drive ? mem[mar] : 8'hzz;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= LOAD;
            load_addr <= LOAD_BASE;
            ld_count  <= 9'd0;
            out_port  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (ld_fire) begin
                load_addr <= load_addr + 8'd1;
                if (ld_count != 9'd256) begin
                    ld_count <= ld_count + 9'd1;
                end
            end
            if (cpu_wr && (mar == OUT_ADDR)) begin
                out_port <= mbr;
            end
        end
    end

    // Contents survive reset so an abandoned load keeps its earlier bytes.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (ld_fire) begin
                mem[load_addr] <= ld_data;
            end else if (cpu_wr) begin
                mem[mar] <= mbr;
            end
        end
    end

endmodule

// File: tb/tb_boot_memory.sv
// Bench for boot_memory: memory model plus a queue of expected bus reads.
module tb_boot_memory;

    logic       clock;
    logic       reset;
    logic [7:0] mar;
    logic       we;
    wire  [7:0] mbr;
    logic [7:0] tb_bus;
    logic       tb_drv;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       cpu_reset;
    logic [7:0] out_port;
    logic [8:0] ld_count;

    logic [7:0] model [256];
    logic [7:0] model_addr;
    int         model_count;
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int         pass_cnt;
    int         total_cnt;

    assign mbr = tb_drv ? tb_bus : 8'hzz;

    boot_memory #(.LOAD_BASE(8'h00), .OUT_ADDR(8'hFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .mar       (mar),
        .we        (we),
        .mbr       (mbr),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .cpu_reset (cpu_reset),
        .out_port  (out_port),
        .ld_count  (ld_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_addr  = 8'h00;
        model_count = 0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        model[model_addr] = d;
        model_addr = model_addr + 8'd1;
        if (model_count < 256) model_count++;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Set up a processor read and queue the byte the bus should carry.
    task automatic issue_read(input logic [7:0] a);
        we     = 1'b0;
        tb_drv = 1'b0;
        mar    = a;
        exp_q.push_back(model[a]);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        we     = 1'b1;
        tb_drv = 1'b1;
        tb_bus = d;
        mar    = a;
        tick();
        model[a] = d;
        we     = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %b exp 1", ld_ready);
        else pass_cnt++;
        total_cnt++;
        if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset);
        else pass_cnt++;
        total_cnt++;
        if (ld_count !== 9'd0) $display("FAIL reset_ld_count got %0d exp 0", ld_count);
        else pass_cnt++;
        total_cnt++;
        if (out_port !== 8'h00) $display("FAIL reset_out_port got %h exp 00", out_port);
        else pass_cnt++;
    endtask

    task automatic test_load();
        do_reset();
        load_byte(8'h41, 1'b0);
        load_byte(8'h52, 1'b0);
        total_cnt++;
        if (cpu_reset !== 1'b1) $display("FAIL load_hold got %b exp 1", cpu_reset);
        else pass_cnt++;
        load_byte(8'hFF, 1'b1);
        total_cnt++;
        if (cpu_reset !== 1'b0) $display("FAIL load_cpu_reset got %b exp 0", cpu_reset);
        else pass_cnt++;
        total_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL load_ld_ready got %b exp 0", ld_ready);
        else pass_cnt++;
        total_cnt++;
        if (ld_count !== 9'd3) $display("FAIL load_count got %0d exp 3", ld_count);
        else pass_cnt++;
        for (int a = 0; a < 3; a++) begin
            issue_read(8'(a));
            e = exp_q.pop_front();
            total_cnt++;
            if (mbr !== e) $display("FAIL load_mem%0d got %h exp %h", a, mbr, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_bus();
        issue_read(8'h01);
        e = exp_q.pop_front();
        total_cnt++;
        if (mbr !== e) $display("FAIL read_async got %h exp %h", mbr, e);
        else pass_cnt++;
        // With the processor driving 00, any block drive of 52 would show up.
        we     = 1'b1;
        tb_drv = 1'b1;
        tb_bus = 8'h00;
        #1;
        total_cnt++;
        if (mbr !== 8'h00) $display("FAIL write_hiz got %h exp 00", mbr);
        else pass_cnt++;
        we     = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic test_out_port();
        cpu_write(8'hFF, 8'h2A);
        total_cnt++;
        if (out_port !== 8'h2A) $display("FAIL out_port got %h exp 2a", out_port);
        else pass_cnt++;
        issue_read(8'hFF);
        e = exp_q.pop_front();
        total_cnt++;
        if (mbr !== e) $display("FAIL out_mem got %h exp %h", mbr, e);
        else pass_cnt++;
        cpu_write(8'hF3, 8'h17);
        total_cnt++;
        if (out_port !== 8'h2A) $display("FAIL out_hold got %h exp 2a", out_port);
        else pass_cnt++;
        issue_read(8'hF3);
        e = exp_q.pop_front();
        total_cnt++;
        if (mbr !== e) $display("FAIL mem_f3 got %h exp %h", mbr, e);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 258; i++) begin
            load_byte(8'(i), i == 257);
            if (i == 254 || i == 255) begin
                total_cnt++;
                if (ld_count !== 9'(model_count))
                    $display("FAIL wrap_count%0d got %0d exp %0d", i, ld_count, model_count);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (ld_count !== 9'd256) $display("FAIL wrap_sat got %0d exp 256", ld_count);
        else pass_cnt++;
        total_cnt++;
        if (out_port !== 8'h00) $display("FAIL wrap_out got %h exp 00", out_port);
        else pass_cnt++;
        for (int a = 0; a < 4; a++) begin
            issue_read(a == 3 ? 8'hFF : 8'(a));
        end
        for (int a = 0; a < 4; a++) begin
            mar = (a == 3) ? 8'hFF : 8'(a);
            #1;
            e = exp_q.pop_front();
            total_cnt++;
            if (mbr !== e) $display("FAIL wrap_mem%0d got %h exp %h", a, mbr, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        tick();
        reset    = 1'b1;
        ld_valid = 1'b0;
        model_addr  = 8'h00;
        model_count = 0;
        total_cnt++;
        if (ld_count !== 9'd0) $display("FAIL mid_count got %0d exp 0", ld_count);
        else pass_cnt++;
        mar    = 8'h01;
        we     = 1'b0;
        tb_drv = 1'b1;
        tb_bus = 8'h00;
        #1;
        total_cnt++;
        if (mbr !== 8'h00) $display("FAIL load_hiz got %h exp 00", mbr);
        else pass_cnt++;
        tb_drv = 1'b0;
        load_byte(8'h99, 1'b1);
        total_cnt++;
        if (ld_count !== 9'd1) $display("FAIL reload_count got %0d exp 1", ld_count);
        else pass_cnt++;
        for (int a = 0; a < 3; a++) begin
            issue_read(8'(a));
            e = exp_q.pop_front();
            total_cnt++;
            if (mbr !== e) $display("FAIL reload_mem%0d got %h exp %h", a, mbr, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_gapped();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load_byte(8'hA0 + 8'(i), 1'b0);
            ld_last = 1'b1;
            tick();
            ld_last = 1'b0;
            total_cnt++;
            if (cpu_reset !== 1'b1) $display("FAIL gap_hold%0d got %b exp 1", i, cpu_reset);
            else pass_cnt++;
        end
        load_byte(8'hA3, 1'b1);
        total_cnt++;
        if (cpu_reset !== 1'b0) $display("FAIL gap_run got %b exp 0", cpu_reset);
        else pass_cnt++;
        total_cnt++;
        if (ld_count !== 9'd4) $display("FAIL gap_count got %0d exp 4", ld_count);
        else pass_cnt++;
        // Loader traffic in RUN must not land at the next loader address.
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        tick();
        ld_valid = 1'b0;
        total_cnt++;
        if (ld_count !== 9'd4) $display("FAIL run_ignore_count got %0d exp 4", ld_count);
        else pass_cnt++;
        for (int a = 0; a < 5; a++) begin
            issue_read(8'(a));
            e = exp_q.pop_front();
            total_cnt++;
            if (mbr !== e) $display("FAIL gap_mem%0d got %h exp %h", a, mbr, e);
            else pass_cnt++;
        end
        do_reset();
        total_cnt++;
        if (cpu_reset !== 1'b1) $display("FAIL run_reset got %b exp 1", cpu_reset);
        else pass_cnt++;
    endtask

    initial begin
        reset     = 1'b0;
        mar       = 8'h00;
        we        = 1'b0;
        tb_bus    = 8'h00;
        tb_drv    = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = 8'h00;
        ld_last   = 1'b0;
        pass_cnt  = 0;
        total_cnt = 0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        model_addr  = 8'h00;
        model_count = 0;
        test_reset();
        test_load();
        test_bus();
        test_out_port();
        test_wrap();
        test_reset_midload();
        test_gapped();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/boot_memory.md
BOOT_MEMORY -- requirements
Module: boot_memory

Interface
REQ-001 Parameter LOAD_BASE, default 8'h00: first address written by the loader.
REQ-002 Parameter OUT_ADDR, default 8'hFF: address of the memory-mapped output port.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 mar  input  8  memory address from the processor.
REQ-006 we  input  1  processor write enable, active-high.
REQ-007 mbr  inout  8  bidirectional data bus shared with the processor.
REQ-008 ld_valid  input  1  loader byte valid.
REQ-009 ld_data  input  8  loader byte.
REQ-010 ld_last  input  1  marks the final loader byte; qualified by ld_valid.
REQ-011 ld_ready  output  1  block accepts a loader byte this cycle.
REQ-012 cpu_reset  output  1  active-high hold to the processor's reset input.
REQ-013 out_port  output  8  registered output-port value.
REQ-014 ld_count  output  9  number of bytes accepted in the current load, saturating at 256.

Function
REQ-015 Storage SHALL be 256 x 8 bits, addressed by the full 8-bit address.
REQ-016 The FSM SHALL have exactly two states, LOAD and RUN.
REQ-017 In LOAD, ld_ready=1, cpu_reset=1, and mbr SHALL be high-impedance.
REQ-018 In LOAD, a handshake (ld_valid & ld_ready) at a rising edge SHALL write ld_data to mem[load_addr], increment load_addr, and increment ld_count.
REQ-019 The loader address SHALL wrap from 8'hFF to 8'h00, overwriting earlier bytes.
REQ-020 ld_count SHALL saturate at 9'd256 when further bytes are accepted.
REQ-021 A handshake with ld_last=1 SHALL store that byte and make the state RUN from the next cycle.
REQ-022 ld_valid=0 in LOAD SHALL hold all state; ld_last without ld_valid SHALL be ignored.
REQ-023 In RUN, ld_ready=0 and cpu_reset=0, and loader inputs SHALL be ignored.
REQ-024 In RUN with we=0, mbr SHALL be driven combinationally with mem[mar]: zero-latency asynchronous read, so data is valid in the cycle after the processor registers mar.
REQ-025 In RUN with we=1, mbr SHALL be high-impedance, and at the rising edge mem[mar] SHALL take mbr.
REQ-026 A RUN write with mar==OUT_ADDR SHALL update both mem[OUT_ADDR] and out_port at the same edge.
REQ-027 Loader writes to OUT_ADDR SHALL update memory only, never out_port.
REQ-028 The block SHALL never drive mbr while we=1 or while in LOAD, so the bus has no contention.
REQ-029 RUN SHALL persist until reset; there is no return path to LOAD otherwise.

Reset
REQ-030 When reset is low at a rising edge: state=LOAD, load_addr=LOAD_BASE, ld_count=0, out_port=8'h00, ld_ready=1, cpu_reset=1.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset mid-load SHALL abandon the load; the next load restarts at LOAD_BASE, and earlier bytes remain in memory.
REQ-033 Reset in RUN SHALL re-enter LOAD and re-assert cpu_reset in the following cycle.
REQ-034 Reset SHALL take priority over a simultaneous loader handshake: the byte is not written.

Verification
REQ-035 Load 3 bytes (0x41, 0x52, 0xFF with ld_last on the third) -> mem[0..2] hold those bytes, ld_count=3, cpu_reset falls one cycle after the third handshake, ld_ready=0.
REQ-036 RUN with mar=0x01, we=0 -> mbr=0x52 in the same cycle; with we=1 -> mbr is high-Z from this block.
REQ-037 RUN: the processor drives mbr=0x2A with we=1 and mar=0xFF -> at the next edge out_port=0x2A and mem[0xFF]=0x2A; a write to mar=0xF3 leaves out_port unchanged.
REQ-038 Stream 258 bytes (value = index[7:0]) then ld_last -> ld_count=256, mem[0x00]=0x00 and mem[0x01]=0x01 from the wrapped writes, mem[0x02]=0x02.
REQ-039 Reset after 2 of 4 bytes, then reload 1 byte 0x99 with ld_last -> mem[0]=0x99, mem[1] keeps its first-load value, ld_count=1.
REQ-040 Gapped ld_valid (alternating 1/0) with ld_last asserted during a ld_valid=0 cycle -> no transition to RUN until a valid last byte is accepted.
